// File: rtl/sweep_defs.sv
// Shared encodings and CRC helpers for the sweep stimulus generator.
package sweep_defs;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_DESC = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

    // One bit of a left-shifting CRC-16, response bit folded in at the MSB.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sweep_sig_acc.sv
// Ones counter and CRC-16 accumulator with result registers loaded at pass end.
module sweep_sig_acc
    import sweep_defs::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_en,
    input  logic             resp,
    input  logic             load,
    output logic [WIDTH:0]   ones_cnt,
    output logic [15:0]      signature
);

    logic [WIDTH:0] ones_reg;
    logic [WIDTH:0] ones_next;
    logic [15:0]    crc_reg;
    logic [15:0]    crc_next;

    // The step values include a sample taken on the same edge as load/clear.
    always_comb begin
        ones_next = ones_reg;
        crc_next  = crc_reg;
        if (sample_en) begin
            ones_next = ones_reg + {{WIDTH{1'b0}}, resp};
            crc_next  = crc_step(crc_reg, resp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_reg  <= '0;
            crc_reg   <= CRC_SEED;
            ones_cnt  <= '0;
            signature <= '0;
        end else begin
            if (load) begin
                ones_cnt  <= ones_next;
                signature <= crc_next;
            end
            if (clear) begin
                ones_reg <= '0;
                crc_reg  <= CRC_SEED;
            end else begin
                ones_reg <= ones_next;
                crc_reg  <= crc_next;
            end
        end
    end

endmodule

// File: rtl/sweep_stim_gen.sv
// Exhaustive input sweeper: FSM, dwell/index counters and vector ordering.
module sweep_stim_gen
    import sweep_defs::*;
#(
    parameter int WIDTH     = 5,
    parameter int DWELL     = 200,
    parameter int SAMPLE_AT = 199
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic             continuous,
    input  logic             resp,
    output logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] vec_idx,
    output logic             sample_stb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   ones_cnt,
    output logic [15:0]      signature
);

    localparam int DW = $clog2(DWELL);

    state_t         state_reg;
    mode_t          mode_reg;
    logic           cont_reg;
    logic [DW-1:0]  dwell_reg;
    logic [WIDTH-1:0] idx_reg;
    logic [WIDTH-1:0] vec_reg;
    logic           done_reg;

    logic dwell_end;
    logic last_vec;
    logic start_ok;
    logic pass_end;

    function automatic logic [WIDTH-1:0] map_vec(input logic [WIDTH-1:0] i, input mode_t m);
        case (m)
            MODE_GRAY: return i ^ (i >> 1);
            MODE_DESC: return ~i;
            default:   return i;
        endcase
    endfunction

    assign dwell_end  = (dwell_reg == DW'(DWELL - 1));
    assign last_vec   = (idx_reg == {WIDTH{1'b1}});
    assign start_ok   = (state_reg == ST_IDLE) && start && !stop;
    assign pass_end   = (state_reg == ST_RUN) && !stop && dwell_end && last_vec;
    assign sample_stb = (state_reg == ST_RUN) && (dwell_reg == DW'(SAMPLE_AT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            mode_reg  <= MODE_BIN;
            cont_reg  <= 1'b0;
            dwell_reg <= '0;
            idx_reg   <= '0;
            vec_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_reg <= ST_RUN;
                        mode_reg  <= mode_t'(mode);
                        cont_reg  <= continuous;
                        dwell_reg <= '0;
                        idx_reg   <= '0;
                        vec_reg   <= map_vec('0, mode_t'(mode));
                    end
                end
                default: begin
                    if (stop) begin
                        // Abort: counters and vector freeze where they are.
                        state_reg <= ST_IDLE;
                    end else if (dwell_end) begin
                        dwell_reg <= '0;
                        idx_reg   <= idx_reg + WIDTH'(1);
                        vec_reg   <= map_vec(idx_reg + WIDTH'(1), mode_reg);
                        if (last_vec) begin
                            done_reg <= 1'b1;
                            if (!cont_reg) state_reg <= ST_IDLE;
                        end
                    end else begin
                        dwell_reg <= dwell_reg + DW'(1);
                    end
                end
            endcase
        end
    end

    assign vec     = vec_reg;
    assign vec_idx = idx_reg;
    assign busy    = (state_reg == ST_RUN);
    assign done    = done_reg;

    sweep_sig_acc #(.WIDTH(WIDTH)) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok || pass_end),
        .sample_en (sample_stb),
        .resp      (resp),
        .load      (pass_end),
        .ones_cnt  (ones_cnt),
        .signature (signature)
    );

endmodule

// File: doc/sweep_stim_gen.md
# sweep_stim_gen

Parametrised, synthesizable stimulus sweeper and response checker for small combinational DUTs. It drives every N-bit input combination in binary, Gray or descending order and holds each vector for a programmable dwell time. At a programmable point in each dwell window it samples the DUT's 1-bit response and folds it into a ones count and a CRC-16 signature. It replaces hand-written fixed-vector benches and allows on-board self-test of lab circuits.

## Interface
Parameters:
- WIDTH, 5, number of DUT inputs (1..16); a pass is 2^WIDTH vectors.
- DWELL, 200, clock cycles each vector is held (>= 2).
- SAMPLE_AT, 199, dwell-counter value at which the response is sampled (0..DWELL-1).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- stop  in  1  abort the sweep; honoured in any state.
- mode  in  2  vector order, latched at start: 0 binary ascending, 1 Gray, 2 binary descending, 3 treated as 0.
- continuous  in  1  latched at start; 1 = repeat passes until stop.
- resp  in  1  DUT response.
- vec  out  WIDTH  vector driven to the DUT.
- vec_idx  out  WIDTH  index of the current vector within the pass.
- sample_stb  out  1  high during the cycle in which resp is captured.
- busy  out  1  a sweep is in progress.
- done  out  1  one-cycle pulse at the end of each completed pass.
- ones_cnt  out  WIDTH+1  number of samples with resp=1 in the last completed pass.
- signature  out  16  CRC-16 of the last completed pass's samples.

## Operation
- Reset values:
  - vec, vec_idx, ones_cnt and signature are 0.
  - busy, done and sample_stb are 0.
  - The state is IDLE.
- States:
  - IDLE to RUN on start, provided stop is low. If stop and start are high in the same cycle, stop wins.
  - RUN to IDLE on stop.
  - RUN to IDLE at the end of the last vector when continuous=0.
  - RUN stays in RUN at the end of the last vector when continuous=1; vec_idx wraps to 0.
- Vector mapping from index i:
  - binary: vec = i.
  - Gray: vec = i ^ (i >> 1).
  - descending: vec = ~i (WIDTH bits).
- Dwell counter:
  - Counts 0..DWELL-1 for each vector.
  - At DWELL-1, vec_idx increments modulo 2^WIDTH.
- Sampling:
  - sample_stb = RUN && dwell_cnt == SAMPLE_AT. It is combinational from registered state.
  - resp is captured at the clock edge that ends a sample_stb cycle.
- Accumulators:
  - At start and at each pass boundary, the ones accumulator is cleared to 0 and the CRC accumulator is seeded to 16'hFFFF.
  - CRC step: fb = crc[15] ^ resp; crc_next = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000).
- Pass end:
  - ones_cnt and signature load the accumulator values, including a final sample taken on the same edge.
  - done pulses for one cycle.
- Stop:
  - No done pulse.
  - ones_cnt and signature keep the previous pass's results.
  - vec and vec_idx hold their last values.
- A start received while busy is ignored; mode and continuous cannot change mid-sweep.

## Timing
- Start is sampled at edge E0. After E0:
  - busy = 1.
  - vec_idx = 0 and vec = map(0).
  - dwell_cnt = 0.
- Vector k is valid for cycles k·DWELL+1 through (k+1)·DWELL after E0.
- busy is high for exactly 2^WIDTH·DWELL cycles per single pass.
- done, ones_cnt and signature update together; busy falls in the same cycle when continuous=0.
- Continuous mode:
  - No idle cycle between passes.
  - done pulses every 2^WIDTH·DWELL cycles.
- stop is sampled at an edge; busy=0 in the following cycle.
- rst asserted at any time forces all outputs to their reset values immediately, without waiting for a clock edge.

## Structure
- Shared include file sweep_defs holds:
  - Mode encodings.
  - State encodings (IDLE, RUN).
  - CRC polynomial 16'h1021 and seed 16'hFFFF.
- Sub-module sweep_sig_acc holds the ones counter and CRC register. Its inputs are clear/seed, sample enable, resp and load-result; its outputs are the result registers.
- Top level holds the FSM, the dwell and index counters and the vector mapping.

## Test plan
- Binary mode, WIDTH=5, DWELL=4, SAMPLE_AT=3, start pulse:
  - vec steps 0..31, each held 4 cycles.
  - busy is high for 128 cycles.
  - A single done pulse coincides with busy falling.
- Gray mode:
  - Sequence starts 0, 1, 3, 2, 6.
  - Every step changes exactly one bit.
  - The last vector is 16.
  - Descending mode starts at 31 and ends at 0.
- resp tied to vec[0] gives ones_cnt = 16; resp = &vec gives ones_cnt = 1. The signature matches the bench CRC model in both cases.
- stop asserted at vec_idx = 10:
  - busy = 0 next cycle; no done pulse.
  - ones_cnt and signature keep the prior pass's values.
  - A later start restarts at vec_idx = 0.
- continuous = 1:
  - Two done pulses 128 cycles apart.
  - vec_idx wraps 31 to 0 with no gap.
  - A start received while busy has no effect.
- rst asserted mid-pass between clock edges:
  - All outputs go to their reset values immediately.
  - After release, the block stays in IDLE until the next start.
